// File: rtl/p2s_pkg.sv
// p2s_pkg: types and defaults shared by the p2s serializer and s2p_buf.
package p2s_pkg;
  typedef enum logic {FILL, HOLD} s2p_state_t;
  localparam int P2S_NUM_DEFAULT = 8;
endpackage

// File: rtl/s2p_buf_if.sv
// s2p_buf_if: serial input and parallel valid/ready output bundle of s2p_buf.
interface s2p_buf_if #(parameter int NUM = 8);
  logic           s_data;
  logic           s_valid;
  logic           s_ready;
  logic [NUM-1:0] p_data;
  logic           p_valid;
  logic           p_ready;
  modport slave  (input s_data, s_valid, p_ready, output s_ready, p_data, p_valid);
  modport master (output s_data, s_valid, p_ready, input s_ready, p_data, p_valid);
endinterface

// File: rtl/s2p_buf.sv
// s2p_buf: reassembles LSB-first serial words and presents them on a
// valid/ready port, with one extra word of buffering in the shift register.
module s2p_buf
  import p2s_pkg::*;
#(
  parameter int NUM = P2S_NUM_DEFAULT
) (
  input  logic      clk,
  input  logic      rstn,
  s2p_buf_if.slave  bus
);
  localparam int CW = $clog2(NUM);
  s2p_state_t     state_q;
  logic [CW-1:0]  cnt_q;
  logic [NUM-1:0] sh_q;
  logic [NUM-1:0] p_data_q;
  logic           p_valid_q;
  logic [NUM-1:0] w;
  logic           s_beat;
  logic           p_beat;
  logic           last;
  assign bus.s_ready = state_q == FILL;
  assign bus.p_data  = p_data_q;
  assign bus.p_valid = p_valid_q;
  assign w      = {bus.s_data, sh_q[NUM-1:1]};
  assign s_beat = bus.s_valid && state_q == FILL;
  assign p_beat = p_valid_q && bus.p_ready;
  assign last   = cnt_q == CW'(NUM - 1);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      sh_q      <= '0;
      p_data_q  <= '0;
      p_valid_q <= 1'b0;
    end else if (state_q == FILL) begin
      if (p_beat) p_valid_q <= 1'b0;
      if (s_beat) begin
        if (!last) begin
          sh_q  <= w;
          cnt_q <= cnt_q + 1'b1;
        end else begin
          cnt_q <= '0;
          // a draining or empty output register takes the word directly
          if (!p_valid_q || bus.p_ready) begin
            p_data_q  <= w;
            p_valid_q <= 1'b1;
          end else begin
            sh_q    <= w;
            state_q <= HOLD;
          end
        end
      end
    end else if (p_beat) begin
      p_data_q <= sh_q;
      state_q  <= FILL;
    end
  end
endmodule

// File: doc/s2p_buf.md
# s2p_buf

Serial-to-parallel converter with a one-word output buffer. It reassembles `NUM`-bit words from the LSB-first bit stream produced by the `p2s` serializer and presents each word on a valid/ready parallel port. A word can finish assembling while the previous word still waits to be consumed, so a continuously ready consumer sees no serial-side bubbles.

## Interface
- `NUM`, default 8: word width in bits; legal range ≥ 2.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `s_data`  in  1: serial bit, LSB of the word first.
- `s_valid`  in  1: `s_data` is valid this cycle.
- `s_ready`  out  1: block accepts a serial bit this cycle.
- `p_data`  out  `NUM`: assembled word.
- `p_valid`  out  1: `p_data` holds a word.
- `p_ready`  in  1: consumer accepts `p_data` this cycle.

## Operation
- **Serial beat:** `s_valid && s_ready` at a rising edge.
  - Each beat shifts in MSB-side: `sh <= {s_data, sh[NUM-1:1]}`.
  - Each beat advances `cnt` (`$clog2(NUM)` bits).
  - `cnt` wraps `NUM-1 -> 0` by explicit compare, so non-power-of-2 `NUM` works.
- **Parallel beat:** `p_valid && p_ready` at a rising edge.
- **FSM `state`:** two states, `FILL` and `HOLD`.
  - `FILL`: `s_ready = 1`.
    - Beat with `cnt != NUM-1`: shift, `cnt++`, stay in `FILL`.
    - Beat with `cnt == NUM-1` (word completes): compute `w = {s_data, sh[NUM-1:1]}` and set `cnt <= 0`.
      - If `!p_valid || p_ready`: `p_data <= w`, `p_valid <= 1`, stay in `FILL`.
      - Otherwise: `sh <= w` and go to `HOLD`.
  - `HOLD`: `s_ready = 0`; serial inputs are ignored.
    - On a parallel beat: `p_data <= sh`, `p_valid` stays 1, go to `FILL`.
- **Output register, in `FILL`:** a parallel beat with no same-edge word completion clears `p_valid`. `p_data` keeps its last value.
- **Output stability:** `p_data` is stable while `p_valid && !p_ready`.
- **Registered outputs:** `s_ready` is decoded from `state` only. There is no combinational path from `p_ready` or `s_valid` to any output.
- **Reset (mid-operation included):**
  - `state = FILL`, `cnt = 0`, `sh = 0`.
  - `p_valid = 0`, `p_data = 0`; `s_ready = 1` while reset is asserted.
  - Any partial or held word is discarded.

## Timing
- **Latency:** last bit accepted at edge k → `p_valid = 1` with the word from edge k, visible cycle k+1 (when the output register is free or draining).
- **Throughput:** with `p_ready` held high, one word per `NUM` serial beats and `s_ready` never drops.
- **Blocked output:** completing a word at edge k while `p_valid && !p_ready` gives `s_ready = 0` from cycle k+1.
  - A parallel beat at edge m loads the held word.
  - `s_ready = 1` from cycle m+1.
- **Simultaneous events:**
  - A word completes on the same edge as a parallel beat: the new word replaces the old one with no gap in `p_valid`.
  - In `HOLD`, a parallel beat and `s_valid` on the same edge: the serial bit is not accepted, because `s_ready` was 0.
- **Idle cycles:** `s_valid` low between beats does not disturb `cnt` or `sh`.

## Structure
- **Shared package `p2s_pkg`** (also used by `p2s`):
  - `typedef enum logic {FILL, HOLD} s2p_state_t`.
  - `localparam int P2S_NUM_DEFAULT = 8`.
- **Sub-modules:** none. FSM, counter, shift register and output register live in `s2p_buf`.

## Test plan
All tests use `NUM = 8`.
- **Reset values:** assert `rstn = 0` mid-run → `p_valid = 0`, `p_data = 8'h00`, `s_ready = 1` immediately, with no clock edge needed.
- **Single word:** bits 1,0,1,0,0,1,0,1 on consecutive cycles with `p_ready = 1` → `p_valid` high for exactly one cycle, the cycle after the 8th beat, with `p_data = 8'hA5`.
- **Blocked output:** words `8'h3C` then `8'hC3` sent back-to-back with `p_ready = 0`.
  - `s_ready` drops after the 16th beat; `p_data = 8'h3C` stays stable.
  - Pulse `p_ready` for one cycle → `p_data = 8'hC3` next cycle, `s_ready = 1`.
- **Serial gaps:** word `8'h81` with `s_valid` low on random cycles between bits → `p_data = 8'h81`; count advances only on beats.
- **Reset mid-word:** reset after 5 bits, then send `8'h5A` → output is `8'h5A`, not a mix of old and new bits.
- **Loopback:** `p2s` feeding `s2p_buf`, words `8'h00, 8'hFF, 8'h5A, 8'hA5`, random `p_ready` → the same words come out in order, none lost or duplicated.
